// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map, bit indices, FSM states.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
package uart_tx_pkg;

  // Register offsets expressed as word indices (byte offset / 4).
  localparam logic [7:0] OFS_TXDATA = 8'h00;
  localparam logic [7:0] OFS_STATUS = 8'h01;
  localparam logic [7:0] OFS_DIV    = 8'h02;
  localparam logic [7:0] OFS_CTRL   = 8'h03;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_PARITY    = 16;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Simple system bus: request granted in the same cycle, one registered response the next cycle.
// Handshake: every cycle with req_i high is one transfer; rvalid_o pulses exactly one cycle later.
interface uart_tx_if #(
  parameter int AddrWidth = 32
) ();
  logic                 req_i;
  logic                 we_i;
  logic [3:0]           be_i;
  logic [AddrWidth-1:0] addr_i;
  logic [31:0]          wdata_i;
  logic                 rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the oldest entry; push when full is ignored.
module uart_tx_fifo #(
  parameter int Depth = 16,
  parameter int Width = 8,
  localparam int PtrW = $clog2(Depth),
  localparam int LvlW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LvlW-1:0]  level
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [LvlW-1:0]  count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LvlW'(Depth));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LvlW'(1);
        2'b01:   count <= count - LvlW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter: bus register file, TX FIFO, baud-paced frame FSM, level IRQ.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_dev
  import uart_tx_pkg::*;
#(
  parameter int          FifoDepth = 16,
  parameter logic [15:0] DivReset  = 16'd433,
  parameter int          AddrWidth = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_if.slave       bus,
  output logic           tx_o,
  output logic           irq_o,
  output uart_tx_state_e state_o
);

  localparam int LvlW = $clog2(FifoDepth) + 1;

  // Bus decode
  logic [7:0]  word;
  logic        wr;
  logic        push;
  logic [31:0] status;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Registers
  logic [15:0] div_q;
  logic        tx_en_q;
  logic        irq_en_q;
  logic        ovf_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        irq_q;

  // FIFO
  logic [7:0]      fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LvlW-1:0] fifo_level;
  logic            pop;

  // Frame FSM
  uart_tx_state_e state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [15:0]    div_lat_q, div_lat_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic           tx_q, tx_d;
  logic           start_ok;
  logic           busy;

  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[AddrWidth-1:10], bus.addr_i[1:0],
                         bus.wdata_i[31:16], bus.be_i[3:2]};

  assign word = bus.addr_i[9:2];
  assign wr   = bus.req_i & bus.we_i;
  assign push = wr & (word == OFS_TXDATA) & bus.be_i[0];
  assign busy = (state_q != S_IDLE);

  always_comb begin
    status = '0;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = busy;
    status[STAT_OVF]   = ovf_q;
    status[STAT_LEVEL_LSB +: LvlW] = fifo_level;
    status[STAT_PARITY] = PARITY_EN;
  end

  always_comb begin
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (word)
      OFS_TXDATA: rsp_rdata = '0;
      OFS_STATUS: if (!bus.we_i) rsp_rdata = status;
      OFS_DIV:    if (!bus.we_i) rsp_rdata = {16'h0000, div_q};
      OFS_CTRL:   if (!bus.we_i) rsp_rdata = {30'd0, irq_en_q, tx_en_q};
      default:    rsp_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      div_q    <= DivReset;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.req_i;
      rdata_q  <= bus.req_i ? rsp_rdata : '0;
      err_q    <= bus.req_i ? rsp_err : 1'b0;
      // Full is the pre-edge value, so a same-cycle pop never rescues the push.
      if (push && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr && word == OFS_STATUS && bus.be_i[0] && bus.wdata_i[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
      if (wr && word == OFS_DIV) begin
        if (bus.be_i[0]) div_q[7:0]  <= bus.wdata_i[7:0];
        if (bus.be_i[1]) div_q[15:8] <= bus.wdata_i[15:8];
      end
      if (wr && word == OFS_CTRL && bus.be_i[0]) begin
        tx_en_q  <= bus.wdata_i[CTRL_TX_EN];
        irq_en_q <= bus.wdata_i[CTRL_IRQ_EN];
      end
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

  uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (bus.wdata_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign start_ok = tx_en_q & ~fifo_empty;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_lat_d = div_lat_q;
    bit_d     = bit_q;
    data_d    = data_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          pop       = 1'b1;
          state_d   = S_START;
          data_d    = fifo_rdata;
          div_lat_d = div_q;
          baud_d    = div_q;
          tx_d      = 1'b0;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = div_lat_q;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = div_lat_q;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = ^data_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = div_lat_q;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next frame so back-to-back bytes carry no idle gap.
          if (start_ok) begin
            pop       = 1'b1;
            state_d   = S_START;
            data_d    = fifo_rdata;
            div_lat_d = div_q;
            baud_d    = div_q;
            tx_d      = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      div_lat_q <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      div_lat_q <= div_lat_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      irq_q     <= irq_en_q & fifo_empty & ~busy;
    end
  end

  assign tx_o    = tx_q;
  assign irq_o   = irq_q;
  assign state_o = state_q;

endmodule
